// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
//   Round-robin arbiter that lets N_REQ requesters share a single I2C master.
//   In IDLE it picks the next active requester after the last one served,
//   latches that requester's command, and waits until the master is free.
//   It then pulses m_start and waits for m_done, or gives up after a timeout.
//   Finally it pulses done to the winner and returns to IDLE.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   req_i             per-requester request level, held until its done
//   req_addr_i        packed 7-bit slave address, slot i = [7i+6:7i]
//   req_rw_i          per-requester direction (1 = read)
//   req_wdata_i       packed write byte, slot i = [8i+7:8i]
//   gnt_o             one-hot grant, held from GRANT through RESP
//   done_o            one-cycle completion pulse to the granted requester
//   rdata_o           read byte of the last completed transaction
//   err_o             last transaction ended in NACK or timeout
//   timeout_o         last transaction ended in timeout
//   busy_o            high whenever the FSM is not in IDLE
//   m_start_o         one-cycle start command to the I2C master
//   m_addr_o/m_rw_o/m_wdata_o  command fields to the master
//   m_busy_i/m_done_i/m_nack_i/m_rdata_i  master status and response
// ---------------------------------------------------------------------------
module i2c_req_arbiter #(
  parameter int N_REQ     = 4,     // 2..8
  parameter int TO_CYCLES = 1000   // >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [7*N_REQ-1:0] req_addr_i,
  input  logic [N_REQ-1:0]   req_rw_i,
  input  logic [8*N_REQ-1:0] req_wdata_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [7:0]         rdata_o,
  output logic               err_o,
  output logic               timeout_o,
  output logic               busy_o,
  output logic               m_start_o,
  output logic [6:0]         m_addr_o,
  output logic               m_rw_o,
  output logic [7:0]         m_wdata_o,
  input  logic               m_busy_i,
  input  logic               m_done_i,
  input  logic               m_nack_i,
  input  logic [7:0]         m_rdata_i
);

  localparam int IDX_W = $clog2(N_REQ);
  // The counter only has to hold values up to TO_CYCLES-1.
  localparam int CNT_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               tout_q, tout_d;

  // Per-slot views of the packed request fields.
  logic [6:0] addr_arr  [N_REQ];
  logic [7:0] wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[7*g +: 7];
    assign wdata_arr[g] = req_wdata_i[8*g +: 8];
  end

  // Round-robin pick: first active request scanning upward from last+1,
  // wrapping at N_REQ. last resets to N_REQ-1 so slot 0 is scanned first.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a signal unassigned (no latch).
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tout_d  = tout_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          addr_d  = addr_arr[win_idx];
          rw_d    = req_rw_i[win_idx];
          wdata_d = wdata_arr[win_idx];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!m_busy_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The timeout fires on the cycle the counter reaches TO_CYCLES-1,
        // so RESP follows ISSUE by exactly TO_CYCLES cycles. A coincident
        // m_done takes priority.
        cnt_d = cnt_q + 1'b1;
        if (m_done_i) begin
          err_d   = m_nack_i;
          tout_d  = 1'b0;
          rdata_d = rw_q ? m_rdata_i : 8'h00;
          state_d = S_RESP;
        end else if (cnt_d == CNT_LAST) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          rdata_d = 8'h00;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  // Grant and done are decoded from state, so reset clears them at once.
  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    if (state_q != S_IDLE) gnt_o[idx_q]  = 1'b1;
    if (state_q == S_RESP) done_o[idx_q] = 1'b1;
  end

  assign busy_o    = (state_q != S_IDLE);
  assign m_start_o = (state_q == S_ISSUE);
  assign m_addr_o  = addr_q;
  assign m_rw_o    = rw_q;
  assign m_wdata_o = wdata_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign timeout_o = tout_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_req_arbiter
//   Directed bench for i2c_req_arbiter. u_dut uses the default timeout and
//   covers the single write, round robin, read NACK, busy master and reset
//   cases. u_to uses TO_CYCLES=16 and covers the timeout boundary. Both
//   instances share the same stimulus and reset, and each case starts from
//   a reset. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_i2c_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [3:0]  req_rw = '0;
  logic [31:0] req_wdata = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_nack = 1'b0;
  logic [7:0]  m_rdata = '0;

  logic [3:0] gnt, done;
  logic [7:0] rdata, m_wdata;
  logic       err, timeout, busy, m_start, m_rw;
  logic [6:0] m_addr;

  logic [3:0] to_gnt, to_done;
  logic [7:0] to_rdata, to_m_wdata;
  logic       to_err, to_timeout, to_busy, to_m_start, to_m_rw;
  logic [6:0] to_m_addr;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.N_REQ(4), .TO_CYCLES(1000)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .req_addr_i(req_addr),
    .req_rw_i(req_rw), .req_wdata_i(req_wdata), .gnt_o(gnt), .done_o(done),
    .rdata_o(rdata), .err_o(err), .timeout_o(timeout), .busy_o(busy),
    .m_start_o(m_start), .m_addr_o(m_addr), .m_rw_o(m_rw),
    .m_wdata_o(m_wdata), .m_busy_i(m_busy), .m_done_i(m_done),
    .m_nack_i(m_nack), .m_rdata_i(m_rdata)
  );

  i2c_req_arbiter #(.N_REQ(4), .TO_CYCLES(16)) u_to (
    .clk(clk), .rst(rst), .req_i(req), .req_addr_i(req_addr),
    .req_rw_i(req_rw), .req_wdata_i(req_wdata), .gnt_o(to_gnt),
    .done_o(to_done), .rdata_o(to_rdata), .err_o(to_err),
    .timeout_o(to_timeout), .busy_o(to_busy), .m_start_o(to_m_start),
    .m_addr_o(to_m_addr), .m_rw_o(to_m_rw), .m_wdata_o(to_m_wdata),
    .m_busy_i(m_busy), .m_done_i(m_done), .m_nack_i(m_nack),
    .m_rdata_i(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req    = '0;
    req_rw = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_nack = 1'b0;
    m_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int waited;
    exp_order = '{0, 1, 2, 3, 0};

    // ---------------- single write ----------------
    do_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_start", m_start, 1'b0);
    req_addr[6:0]  = 7'h50;
    req_wdata[7:0] = 8'hA5;
    req_rw[0]      = 1'b0;
    req            = 4'b0001;              // cycle 0: seen in IDLE
    step();                                // cycle 1
    check("wr_gnt_c1", gnt, 4'b0001);
    check("wr_start_c1", m_start, 1'b0);
    check("wr_busy_c1", busy, 1'b1);
    step();                                // cycle 2
    check("wr_start_c2", m_start, 1'b1);
    check("wr_addr", m_addr, 7'h50);
    check("wr_rw", m_rw, 1'b0);
    check("wr_wdata", m_wdata, 8'hA5);
    repeat (20) step();                    // m_start + 20
    check("wr_wait_done", done, 4'b0000);
    check("wr_wait_gnt", gnt, 4'b0001);
    check("wr_wait_addr", m_addr, 7'h50);
    m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'hEE;
    step();
    m_done = 1'b0; m_rdata = 8'h00;
    check("wr_done", done, 4'b0001);
    check("wr_err", err, 1'b0);
    check("wr_timeout", timeout, 1'b0);
    check("wr_rdata", rdata, 8'h00);
    req = 4'b0000;
    step();
    check("wr_done_1cyc", done, 4'b0000);
    check("wr_idle_gnt", gnt, 4'b0000);
    check("wr_idle_busy", busy, 1'b0);

    // ---------------- round robin ----------------
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[7*i +: 7] = 7'(7'h10 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr%0d_gnt", k), gnt, 32'(1 << exp_order[k]));
      check($sformatf("rr%0d_addr", k), m_addr, 32'(7'h10 + exp_order[k]));
      step();
      check($sformatf("rr%0d_start", k), m_start, 1'b1);
      step();
      step();
      check($sformatf("rr%0d_nodone", k), done, 4'b0000);
      m_done = 1'b1;
      step();
      m_done = 1'b0;
      check($sformatf("rr%0d_done", k), done, 32'(1 << exp_order[k]));
      step();
      check($sformatf("rr%0d_idle_done", k), done, 4'b0000);
      check($sformatf("rr%0d_idle_busy", k), busy, 1'b0);
    end

    // ---------------- read with NACK ----------------
    do_reset();
    req_addr[20:14] = 7'h3A;
    req_rw          = 4'b0100;
    req             = 4'b0100;
    step();
    check("rd_gnt", gnt, 4'b0100);
    check("rd_rw", m_rw, 1'b1);
    check("rd_addr", m_addr, 7'h3A);
    step();
    check("rd_start", m_start, 1'b1);
    step();
    step();
    m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h3C;
    step();
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    check("rd_done", done, 4'b0100);
    check("rd_err", err, 1'b1);
    check("rd_timeout", timeout, 1'b0);
    check("rd_rdata", rdata, 8'h3C);
    req = 4'b0000;
    step();
    check("rd_hold_rdata", rdata, 8'h3C);
    check("rd_hold_err", err, 1'b1);
    check("rd_hold_done", done, 4'b0000);

    // ---------------- reset in WAIT (status still from read) ----------------
    req_addr[6:0]  = 7'h2A;
    req_wdata[7:0] = 8'hFF;
    req_rw         = 4'b0000;
    req            = 4'b0001;
    step();
    step();
    step();
    step();
    check("rw_pre_busy", busy, 1'b1);
    check("rw_pre_wdata", m_wdata, 8'hFF);
    #2;
    rst = 1'b1;
    #1;                                    // no clock edge since rst rose
    check("rw_async_gnt", gnt, 4'b0000);
    check("rw_async_busy", busy, 1'b0);
    check("rw_async_done", done, 4'b0000);
    check("rw_async_start", m_start, 1'b0);
    check("rw_async_addr", m_addr, 7'h00);
    check("rw_async_rw", m_rw, 1'b0);
    check("rw_async_wdata", m_wdata, 8'h00);
    check("rw_async_rdata", rdata, 8'h00);
    check("rw_async_err", err, 1'b0);
    check("rw_async_timeout", timeout, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rw_hold%0d_done", k), done, 4'b0000);
    end
    req = 4'b0110;
    rst = 1'b0;
    step();
    check("rw_first_gnt", gnt, 4'b0010);

    // ---------------- busy master; req dropped after grant ----------------
    do_reset();
    m_busy          = 1'b1;
    req_addr[27:21] = 7'h77;
    req             = 4'b1000;
    step();                                // GRANT
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bz%0d_gnt", k), gnt, 4'b1000);
      check($sformatf("bz%0d_start", k), m_start, 1'b0);
      check($sformatf("bz%0d_done", k), done, 4'b0000);
      m_done = (k == 2);                   // stray m_done outside WAIT
      if (k == 1) req = 4'b0000;           // drop request after grant
      step();
    end
    m_done = 1'b0;
    m_busy = 1'b0;
    check("bz_free_start", m_start, 1'b0);
    step();
    check("bz_start", m_start, 1'b1);
    check("bz_start_gnt", gnt, 4'b1000);
    check("bz_start_addr", m_addr, 7'h77);
    step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("bz_done", done, 4'b1000);

    // ---------------- timeout (u_to, TO_CYCLES=16) ----------------
    do_reset();
    req_addr[6:0] = 7'h11;
    req           = 4'b0001;
    step();
    step();                                // ISSUE
    check("to_start", to_m_start, 1'b1);
    check("to_addr", to_m_addr, 7'h11);
    waited = 0;
    while (to_done == 4'b0000 && waited < 40) begin
      step();
      waited++;
    end
    check("to_latency", waited, 16);
    check("to_done", to_done, 4'b0001);
    check("to_err", to_err, 1'b1);
    check("to_timeout", to_timeout, 1'b1);
    check("to_rdata", to_rdata, 8'h00);
    req = 4'b0000;
    step();
    check("to_idle_busy", to_busy, 1'b0);

    // m_done on the boundary cycle 15 wins over the timeout
    do_reset();
    req_rw = 4'b0001;
    req    = 4'b0001;
    step();
    step();                                // ISSUE
    repeat (15) step();                    // cycle 15 after ISSUE
    check("tb_pre_done", to_done, 4'b0000);
    check("tb_pre_gnt", to_gnt, 4'b0001);
    m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h5A;
    step();
    m_done = 1'b0; m_rdata = 8'h00;
    check("tb_done", to_done, 4'b0001);
    check("tb_err", to_err, 1'b0);
    check("tb_timeout", to_timeout, 1'b0);
    check("tb_rdata", to_rdata, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
